hid_keyb_fifo: RTL and testbench

- Parametrised PS/2 scan-code receive queue with a memory-mapped register interface on the hid bus, clocked by msoc_clk.
- Replaces the fixed 9-bit FIFO18E1 keyboard path with a generic RTL FIFO that has configurable depth and code width.
- Adds registered read data, an occupancy count, a sticky overflow flag with a drop counter, and a threshold interrupt.
- Sits between the ps2 receiver and the hid address decoder, in the one-hot slot for the keyboard.

---
 rtl/hid_keyb_fifo.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_hid_keyb_fifo.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hid_keyb_fifo.sv
// -----------------------------------------------------------------------------
// hid_keyb_fifo
//
// Receive queue for PS/2 scan codes, exposed to the hid bus as four 64-bit
// registers selected by hid_addr[4:3]:
//   0 DATA   (read pops)  [CODE_W-1:0] code, [CODE_W] released, [16] valid
//   1 STATUS (read-only)  [0] empty, [1] full, [2] overflow, [3] tx_error,
//                         [4] timestamps present, [15:8] drop_cnt,
//                         [31:16] count
//   2 CTRL   (RW)         [0] irq_en, [31:16] thresh (byte enables honoured)
//   3 CLR    (write-only) wrdata[0]=1 clears overflow and drop_cnt
//
// Ports:
//   msoc_clk                 sole clock, rising edge
//   rstn                     synchronous active-low reset
//   scan_ready               level from the ps2 receiver; rising edge = new code
//   scan_code                code, sampled on the scan_ready rising edge
//   scan_released            break flag, sampled with scan_code
//   tx_error_no_keyboard_ack status passthrough into STATUS[3]
//   hid_en                   bus access strobe, one cycle per access
//   hid_be                   byte enables; nonzero = write, zero = read
//   hid_addr                 byte address; only [4:3] decoded
//   hid_wrdata               write data
//   hid_rddata               read data, valid the cycle after a read, held
//   irq                      level interrupt: irq_en & (count >= max(thresh,1)
//                            | overflow), registered
//
// Optional feature macro: HID_KEYB_TIMESTAMP_EN
//   When defined, a TS_W-bit free-running cycle counter is stored with every
//   entry and returned in DATA[32+TS_W-1:32]; STATUS[4] reads 1.
// -----------------------------------------------------------------------------
module hid_keyb_fifo #(
  parameter int DEPTH  = 512,
  parameter int CODE_W = 8,
  parameter int TS_W   = 32
) (
  input  logic              msoc_clk,
  input  logic              rstn,
  input  logic              scan_ready,
  input  logic [CODE_W-1:0] scan_code,
  input  logic              scan_released,
  input  logic              tx_error_no_keyboard_ack,
  input  logic              hid_en,
  input  logic [7:0]        hid_be,
  input  logic [18:0]       hid_addr,
  input  logic [63:0]       hid_wrdata,
  output logic [63:0]       hid_rddata,
  output logic              irq
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int ENT_W = CODE_W + 1;
`ifdef HID_KEYB_TIMESTAMP_EN
  localparam int   MEM_W  = ENT_W + TS_W;
  localparam logic HAS_TS = 1'b1;
`else
  localparam int   MEM_W  = ENT_W;
  localparam logic HAS_TS = 1'b0;
`endif

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLR    = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              scan_ready_q;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              irq_en;
  logic [15:0]       thresh;

  // Read-side registers. DATA reads are served straight from the RAM output
  // register (mem_q), which only loads on a pop, so it already holds its value
  // until the next read. Every other register is captured into rd_reg.
  logic              data_sel;
  logic              data_valid;
  logic [63:0]       rd_reg;

  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  mem_q;

`ifdef HID_KEYB_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic       rd_strobe;
  logic       wr_strobe;
  logic [1:0] reg_sel;
  logic       empty;
  logic       full;
  logic       scan_edge;
  logic       pop;
  logic       push;
  logic       drop;
  logic       clr;

  assign rd_strobe = hid_en & (hid_be == 8'h00);
  assign wr_strobe = hid_en & (hid_be != 8'h00);
  assign reg_sel   = hid_addr[4:3];

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));

  assign scan_edge = scan_ready & ~scan_ready_q;
  assign pop       = rd_strobe & (reg_sel == REG_DATA) & ~empty;
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign push      = scan_edge & (~full | pop);
  assign drop      = scan_edge & full & ~pop;
  assign clr       = wr_strobe & (reg_sel == REG_CLR) & hid_wrdata[0];

  // ---------------------------------------------------------------------------
  // Storage: simple dual-port RAM, registered read-first port. When the queue
  // is full and a push and pop coincide, both hit the same address and the
  // read-first behaviour returns the oldest entry as required.
  // ---------------------------------------------------------------------------
  logic [MEM_W-1:0] entry;

`ifdef HID_KEYB_TIMESTAMP_EN
  assign entry = {ts_cnt, scan_released, scan_code};
`else
  assign entry = {scan_released, scan_code};
`endif

  always_ff @(posedge msoc_clk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
    if (pop) begin
      mem_q <= mem[rd_ptr];
    end
  end

`ifdef HID_KEYB_TIMESTAMP_EN
  always_ff @(posedge msoc_clk) begin
    if (!rstn) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Queue control, flags and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge msoc_clk) begin
    if (!rstn) begin
      scan_ready_q <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      drop_cnt     <= 8'd0;
    end else begin
      scan_ready_q <= scan_ready;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A drop in the same cycle as a clear wins: the new loss must be seen.
      if (drop) begin
        overflow <= 1'b1;
        if (clr) begin
          drop_cnt <= 8'd1;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (clr) begin
        overflow <= 1'b0;
        drop_cnt <= 8'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control register
  // ---------------------------------------------------------------------------
  always_ff @(posedge msoc_clk) begin
    if (!rstn) begin
      irq_en <= 1'b0;
      thresh <= 16'd0;
    end else if (wr_strobe && (reg_sel == REG_CTRL)) begin
      if (hid_be[0]) irq_en        <= hid_wrdata[0];
      if (hid_be[2]) thresh[7:0]   <= hid_wrdata[23:16];
      if (hid_be[3]) thresh[15:8]  <= hid_wrdata[31:24];
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt: a threshold of 0 behaves as 1 so irq never fires on empty.
  // ---------------------------------------------------------------------------
  logic [15:0] thresh_eff;
  logic [31:0] count_ext;

  assign thresh_eff = (thresh == 16'd0) ? 16'd1 : thresh;
  assign count_ext  = 32'(count);

  always_ff @(posedge msoc_clk) begin
    if (!rstn) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & ((count_ext >= {16'd0, thresh_eff}) | overflow);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [63:0] status_word;
  logic [63:0] ctrl_word;
  logic [63:0] data_word;

  always_comb begin
    status_word        = '0;
    status_word[0]     = empty;
    status_word[1]     = full;
    status_word[2]     = overflow;
    status_word[3]     = tx_error_no_keyboard_ack;
    status_word[4]     = HAS_TS;
    status_word[15:8]  = drop_cnt;
    status_word[31:16] = count_ext[15:0];
  end

  always_comb begin
    ctrl_word        = '0;
    ctrl_word[0]     = irq_en;
    ctrl_word[31:16] = thresh;
  end

  // A pop on empty leaves mem_q stale; data_valid masks it to all zeros.
  always_comb begin
    data_word = '0;
    if (data_valid) begin
      data_word[CODE_W-1:0] = mem_q[CODE_W-1:0];
      data_word[CODE_W]     = mem_q[CODE_W];
`ifdef HID_KEYB_TIMESTAMP_EN
      data_word[32 +: TS_W] = mem_q[ENT_W +: TS_W];
`endif
      data_word[16]         = 1'b1;
    end
  end

  always_ff @(posedge msoc_clk) begin
    if (!rstn) begin
      data_sel   <= 1'b0;
      data_valid <= 1'b0;
      rd_reg     <= '0;
    end else if (rd_strobe) begin
      data_sel   <= (reg_sel == REG_DATA);
      data_valid <= pop;
      case (reg_sel)
        REG_STATUS: rd_reg <= status_word;
        REG_CTRL:   rd_reg <= ctrl_word;
        default:    rd_reg <= '0;
      endcase
    end
  end

  // Both sources are flop outputs selected by a flop.
  assign hid_rddata = data_sel ? data_word : rd_reg;

  // Address and data bits that this slot never decodes.
  logic unused_bits;
  assign unused_bits = ^{hid_addr[18:5], hid_addr[2:0],
                         hid_wrdata[63:32], hid_wrdata[15:1]};

endmodule

// File: tb/tb_hid_keyb_fifo.sv
module tb_hid_keyb_fifo;

  localparam int DEPTH  = 4;
  localparam int CODE_W = 8;
  localparam int TS_W   = 32;

`ifdef HID_KEYB_TIMESTAMP_EN
  localparam logic [63:0] TS_BIT    = 64'h10;
  localparam logic [63:0] DATA_MASK = 64'h0000_0000_FFFF_FFFF;
`else
  localparam logic [63:0] TS_BIT    = 64'h0;
  localparam logic [63:0] DATA_MASK = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

  logic              msoc_clk;
  logic              rstn;
  logic              scan_ready;
  logic [CODE_W-1:0] scan_code;
  logic              scan_released;
  logic              tx_error_no_keyboard_ack;
  logic              hid_en;
  logic [7:0]        hid_be;
  logic [18:0]       hid_addr;
  logic [63:0]       hid_wrdata;
  logic [63:0]       hid_rddata;
  logic              irq;

  int checks;
  int errors;

  hid_keyb_fifo #(
    .DEPTH (DEPTH),
    .CODE_W(CODE_W),
    .TS_W  (TS_W)
  ) dut (
    .msoc_clk                (msoc_clk),
    .rstn                    (rstn),
    .scan_ready              (scan_ready),
    .scan_code               (scan_code),
    .scan_released           (scan_released),
    .tx_error_no_keyboard_ack(tx_error_no_keyboard_ack),
    .hid_en                  (hid_en),
    .hid_be                  (hid_be),
    .hid_addr                (hid_addr),
    .hid_wrdata              (hid_wrdata),
    .hid_rddata              (hid_rddata),
    .irq                     (irq)
  );

  initial msoc_clk = 1'b0;
  always #5 msoc_clk = ~msoc_clk;

  task automatic tick();
    @(posedge msoc_clk);
    #1;
  endtask

  task automatic do_reset();
    rstn                     = 1'b0;
    scan_ready               = 1'b0;
    scan_code                = '0;
    scan_released            = 1'b0;
    tx_error_no_keyboard_ack = 1'b0;
    hid_en                   = 1'b0;
    hid_be                   = 8'h00;
    hid_addr                 = '0;
    hid_wrdata               = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // One rising edge of scan_ready, then low again so the next edge is seen.
  task automatic push(input logic [7:0] code, input logic rel);
    scan_code     = code;
    scan_released = rel;
    scan_ready    = 1'b1;
    tick();
    scan_ready    = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [63:0] data);
    hid_en   = 1'b1;
    hid_be   = 8'h00;
    hid_addr = {14'd0, sel, 3'd0};
    tick();
    hid_en   = 1'b0;
    data     = hid_rddata;
    $display("read  reg=%0d data=%h", sel, data);
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [63:0] data,
                           input logic [7:0] be);
    hid_en     = 1'b1;
    hid_be     = be;
    hid_addr   = {14'd0, sel, 3'd0};
    hid_wrdata = data;
    tick();
    hid_en     = 1'b0;
    hid_be     = 8'h00;
    $display("write reg=%0d data=%h be=%h", sel, data, be);
  endtask

  task automatic test_reset();
    logic [63:0] got;
    do_reset();
    checks++;
    if (hid_rddata !== 64'h0) begin
      $display("FAIL reset_rddata got=%h exp=%h", hid_rddata, 64'h0); errors++;
    end
    checks++;
    if (irq !== 1'b0) begin
      $display("FAIL reset_irq got=%b exp=0", irq); errors++;
    end
    bus_read(2'd1, got);
    checks++;
    if (got !== (64'h1 | TS_BIT)) begin
      $display("FAIL reset_status got=%h exp=%h", got, 64'h1 | TS_BIT); errors++;
    end
    bus_read(2'd2, got);
    checks++;
    if (got !== 64'h0) begin
      $display("FAIL reset_ctrl got=%h exp=%h", got, 64'h0); errors++;
    end
  endtask

  task automatic test_fifo_order();
    logic [63:0] got;
    logic [63:0] exp_data [3];
    exp_data[0] = 64'h1001C;
    exp_data[1] = 64'h1011C;
    exp_data[2] = 64'h10032;
    push(8'h1C, 1'b0);
    push(8'h1C, 1'b1);
    push(8'h32, 1'b0);
    bus_read(2'd1, got);
    checks++;
    if (got !== (64'h0003_0000 | TS_BIT)) begin
      $display("FAIL order_status3 got=%h exp=%h", got, 64'h0003_0000 | TS_BIT); errors++;
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(2'd0, got);
      checks++;
      if ((got & DATA_MASK) !== exp_data[i]) begin
        $display("FAIL order_data%0d got=%h exp=%h", i, got & DATA_MASK, exp_data[i]); errors++;
      end
    end
    // A write must not disturb the held read data.
    bus_write(2'd2, 64'h0, 8'hFF);
    checks++;
    if ((hid_rddata & DATA_MASK) !== 64'h10032) begin
      $display("FAIL order_hold got=%h exp=%h", hid_rddata & DATA_MASK, 64'h10032); errors++;
    end
    bus_read(2'd1, got);
    checks++;
    if (got !== (64'h1 | TS_BIT)) begin
      $display("FAIL order_status0 got=%h exp=%h", got, 64'h1 | TS_BIT); errors++;
    end
    bus_read(2'd0, got);
    checks++;
    if (got !== 64'h0) begin
      $display("FAIL order_underflow got=%h exp=%h", got, 64'h0); errors++;
    end
    bus_read(2'd3, got);
    checks++;
    if (got !== 64'h0) begin
      $display("FAIL clr_reads_zero got=%h exp=%h", got, 64'h0); errors++;
    end
  endtask

  task automatic test_overflow();
    logic [63:0] got;
    do_reset();
    for (int i = 1; i <= 6; i++) push(8'(i), 1'b0);
    bus_read(2'd1, got);
    checks++;
    if (got !== (64'h0004_0206 | TS_BIT)) begin
      $display("FAIL ovf_status got=%h exp=%h", got, 64'h0004_0206 | TS_BIT); errors++;
    end
    tx_error_no_keyboard_ack = 1'b1;
    bus_write(2'd3, 64'h1, 8'hFF);
    bus_read(2'd1, got);
    checks++;
    if (got !== (64'h0004_000A | TS_BIT)) begin
      $display("FAIL ovf_clr_status got=%h exp=%h", got, 64'h0004_000A | TS_BIT); errors++;
    end
    tx_error_no_keyboard_ack = 1'b0;
    // Overflowing push coinciding with a CLR write: the set wins.
    scan_code  = 8'h08;
    scan_ready = 1'b1;
    hid_en     = 1'b1;
    hid_be     = 8'hFF;
    hid_addr   = {14'd0, 2'd3, 3'd0};
    hid_wrdata = 64'h1;
    tick();
    scan_ready = 1'b0;
    hid_en     = 1'b0;
    hid_be     = 8'h00;
    tick();
    bus_read(2'd1, got);
    checks++;
    if (got !== (64'h0004_0106 | TS_BIT)) begin
      $display("FAIL ovf_clr_race got=%h exp=%h", got, 64'h0004_0106 | TS_BIT); errors++;
    end
    for (int i = 0; i < 300; i++) push(8'hAA, 1'b0);
    bus_read(2'd1, got);
    checks++;
    if (got !== (64'h0004_FF06 | TS_BIT)) begin
      $display("FAIL ovf_saturate got=%h exp=%h", got, 64'h0004_FF06 | TS_BIT); errors++;
    end
    bus_write(2'd3, 64'h1, 8'hFF);
    bus_read(2'd1, got);
    checks++;
    if (got !== (64'h0004_0002 | TS_BIT)) begin
      $display("FAIL ovf_cleared got=%h exp=%h", got, 64'h0004_0002 | TS_BIT); errors++;
    end
  endtask

  // Continues from test_overflow: queue holds 1,2,3,4 and is full.
  task automatic test_full_push_pop();
    logic [63:0] got;
    logic [63:0] exp_data [4];
    exp_data[0] = 64'h10002;
    exp_data[1] = 64'h10003;
    exp_data[2] = 64'h10004;
    exp_data[3] = 64'h10007;
    scan_code     = 8'h07;
    scan_released = 1'b0;
    scan_ready    = 1'b1;
    hid_en        = 1'b1;
    hid_be        = 8'h00;
    hid_addr      = {14'd0, 2'd0, 3'd0};
    tick();
    scan_ready = 1'b0;
    hid_en     = 1'b0;
    got        = hid_rddata;
    tick();
    checks++;
    if ((got & DATA_MASK) !== 64'h10001) begin
      $display("FAIL full_pp_data got=%h exp=%h", got & DATA_MASK, 64'h10001); errors++;
    end
    bus_read(2'd1, got);
    checks++;
    if (got !== (64'h0004_0002 | TS_BIT)) begin
      $display("FAIL full_pp_status got=%h exp=%h", got, 64'h0004_0002 | TS_BIT); errors++;
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'd0, got);
      checks++;
      if ((got & DATA_MASK) !== exp_data[i]) begin
        $display("FAIL full_drain%0d got=%h exp=%h", i, got & DATA_MASK, exp_data[i]); errors++;
      end
    end
  endtask

  // Continues with an empty queue.
  task automatic test_empty_push_pop();
    logic [63:0] got;
    scan_code     = 8'h55;
    scan_released = 1'b1;
    scan_ready    = 1'b1;
    hid_en        = 1'b1;
    hid_be        = 8'h00;
    hid_addr      = {14'd0, 2'd0, 3'd0};
    tick();
    scan_ready = 1'b0;
    hid_en     = 1'b0;
    got        = hid_rddata;
    tick();
    checks++;
    if (got !== 64'h0) begin
      $display("FAIL empty_pp_data got=%h exp=%h", got, 64'h0); errors++;
    end
    bus_read(2'd1, got);
    checks++;
    if (got !== (64'h0001_0000 | TS_BIT)) begin
      $display("FAIL empty_pp_status got=%h exp=%h", got, 64'h0001_0000 | TS_BIT); errors++;
    end
    bus_read(2'd0, got);
    checks++;
    if ((got & DATA_MASK) !== 64'h10155) begin
      $display("FAIL empty_pp_pop got=%h exp=%h", got & DATA_MASK, 64'h10155); errors++;
    end
  endtask

  task automatic test_ctrl_irq();
    logic [63:0] got;
    do_reset();
    bus_write(2'd2, 64'h0002_0001, 8'hFF);
    bus_read(2'd2, got);
    checks++;
    if (got !== 64'h0002_0001) begin
      $display("FAIL ctrl_readback got=%h exp=%h", got, 64'h0002_0001); errors++;
    end
    push(8'h11, 1'b0);
    checks++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_below got=%b exp=0", irq); errors++;
    end
    scan_code  = 8'h22;
    scan_ready = 1'b1;
    tick();
    checks++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_lag got=%b exp=0", irq); errors++;
    end
    scan_ready = 1'b0;
    tick();
    checks++;
    if (irq !== 1'b1) begin
      $display("FAIL irq_at_thresh got=%b exp=1", irq); errors++;
    end
    bus_read(2'd0, got);
    checks++;
    if ((got & DATA_MASK) !== 64'h10011 || irq !== 1'b1) begin
      $display("FAIL irq_pop_lag got=%h/%b exp=%h/1", got & DATA_MASK, irq, 64'h10011); errors++;
    end
    tick();
    checks++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_after_pop got=%b exp=0", irq); errors++;
    end
    // Byte enable 0 only: irq_en cleared, thresh untouched.
    bus_write(2'd2, 64'hFFFF_0000, 8'h01);
    bus_read(2'd2, got);
    checks++;
    if (got !== 64'h0002_0000) begin
      $display("FAIL ctrl_be got=%h exp=%h", got, 64'h0002_0000); errors++;
    end
    // thresh=0 acts as 1; one entry is queued.
    bus_write(2'd2, 64'h0000_0001, 8'h0F);
    tick();
    checks++;
    if (irq !== 1'b1) begin
      $display("FAIL irq_thresh0 got=%b exp=1", irq); errors++;
    end
    bus_read(2'd0, got);
    tick();
    checks++;
    if ((got & DATA_MASK) !== 64'h10022 || irq !== 1'b0) begin
      $display("FAIL irq_thresh0_empty got=%h/%b exp=%h/0", got & DATA_MASK, irq, 64'h10022); errors++;
    end
    bus_write(2'd2, 64'hFFFF_0001, 8'hFF);
    for (int i = 0; i < 4; i++) push(8'h30, 1'b0);
    checks++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_full_no_ovf got=%b exp=0", irq); errors++;
    end
    push(8'h31, 1'b0);
    checks++;
    if (irq !== 1'b1) begin
      $display("FAIL irq_overflow got=%b exp=1", irq); errors++;
    end
  endtask

`ifdef HID_KEYB_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [63:0] got;
    do_reset();
    repeat (100) tick();
    scan_code  = 8'h40;
    scan_ready = 1'b1;
    tick();
    scan_ready = 1'b0;
    repeat (36) tick();
    scan_code  = 8'h41;
    scan_ready = 1'b1;
    tick();
    scan_ready = 1'b0;
    tick();
    bus_read(2'd0, got);
    checks++;
    if (got !== {32'd100, 32'h10040}) begin
      $display("FAIL ts_first got=%h exp=%h", got, {32'd100, 32'h10040}); errors++;
    end
    bus_read(2'd0, got);
    checks++;
    if (got !== {32'd137, 32'h10041}) begin
      $display("FAIL ts_second got=%h exp=%h", got, {32'd137, 32'h10041}); errors++;
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fifo_order();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_ctrl_irq();
`ifdef HID_KEYB_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
